// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between two
// requesters. It returns each word with a one-cycle valid pulse to its owner.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   req0/addr0       requester 0 level request and address, held until ack0
//   req1/addr1       requester 1 level request and address, held until ack1
//   ack0/ack1        one-cycle pulse when that request is accepted
//   rvalid0/rvalid1  one-cycle pulse when rdata holds that requester's word
//   rdata            last captured ROM word, held until the next capture
//   busy             high while a read is in flight
//   rom_r_en         read enable to the ROM
//   rom_addr         read address to the ROM
//   rom_data         registered read data from the ROM

module rom_rr_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              rom_r_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_n;

    logic              owner, owner_n;
    logic              last, last_n;
    logic              win;
    logic              ack0_n, ack1_n;
    logic              rvalid0_n, rvalid1_n;
    logic              rom_r_en_n;
    logic              busy_n;
    logic [ADDR_W-1:0] rom_addr_n;
    logic [DATA_W-1:0] rdata_n;

    // Under contention the requester not served last wins; a lone
    // requester always wins. win = 1 selects requester 1.
    always_comb begin
        if (req0 && req1) begin
            win = ~last;
        end else begin
            win = req1;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        last_n     = last;
        ack0_n     = 1'b0;
        ack1_n     = 1'b0;
        rvalid0_n  = 1'b0;
        rvalid1_n  = 1'b0;
        rom_r_en_n = 1'b0;
        rom_addr_n = rom_addr;
        rdata_n    = rdata;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    rom_addr_n = win ? addr1 : addr0;
                    rom_r_en_n = 1'b1;
                    ack0_n     = ~win;
                    ack1_n     = win;
                    owner_n    = win;
                    last_n     = win;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                // ROM samples r_en/addr on the edge leaving this state
                state_n = WAIT;
            end
            WAIT: begin
                rdata_n   = rom_data;
                rvalid0_n = ~owner;
                rvalid1_n = owner;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks state exactly
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rom_r_en <= 1'b0;
            rom_addr <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last     <= last_n;
            ack0     <= ack0_n;
            ack1     <= ack1_n;
            rvalid0  <= rvalid0_n;
            rvalid1  <= rvalid1_n;
            rom_r_en <= rom_r_en_n;
            rom_addr <= rom_addr_n;
            rdata    <= rdata_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Directed-vector bench for rom_rr_arbiter with a behavioural 16x16 ROM.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_rom_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        req0;
    logic [3:0]  addr0;
    logic        req1;
    logic [3:0]  addr1;
    logic        ack0;
    logic        ack1;
    logic        rvalid0;
    logic        rvalid1;
    logic [15:0] rdata;
    logic        busy;
    logic        rom_r_en;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;

    logic [15:0] mem [16];

    int n_vec;
    int n_bad;

    logic prev_en;
    logic consec;

    rom_rr_arbiter #(
        .ADDR_W(4),
        .DATA_W(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .addr0   (addr0),
        .req1    (req1),
        .addr1   (addr1),
        .ack0    (ack0),
        .ack1    (ack1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata   (rdata),
        .busy    (busy),
        .rom_r_en(rom_r_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        mem[0]  = 16'h0103; mem[1]  = 16'h5200;
        mem[2]  = 16'he0b9; mem[3]  = 16'h0412;
        mem[4]  = 16'h4839; mem[5]  = 16'h0112;
        mem[6]  = 16'h0377; mem[7]  = 16'h0572;
        mem[8]  = 16'hcafe; mem[9]  = 16'h6225;
        mem[10] = 16'h1447; mem[11] = 16'haeec;
        mem[12] = 16'h52dd; mem[13] = 16'h1113;
        mem[14] = 16'h4444; mem[15] = 16'h5555;
        rom_data = 16'h0000;
    end

    always @(posedge clk) begin
        if (rom_r_en) rom_data <= mem[rom_addr];
    end

    // flags any cycle where rom_r_en stays high two cycles in a row
    always @(negedge clk) begin
        if (rom_r_en && prev_en) consec = 1'b1;
        prev_en = rom_r_en;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    function automatic logic [5:0] flags;
        return {rom_r_en, ack0, ack1, rvalid0, rvalid1, busy};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic got;
        n_vec   = 0;
        n_bad   = 0;
        prev_en = 1'b0;
        consec  = 1'b0;
        rst     = 1'b1;
        req0    = 1'b0;
        req1    = 1'b0;
        addr0   = 4'd0;
        addr1   = 4'd0;

        // reset values
        tick;
        tick;
        chk("rst_flags", flags(), 6'b0);
        chk("rst_addr", rom_addr, 4'd0);
        chk("rst_rdata", rdata, 16'h0);
        rst = 1'b0;
        tick;

        // single read
        req0 = 1'b1; addr0 = 4'd8;
        tick;
        chk("s_ack0", ack0, 1);
        chk("s_ack1", ack1, 0);
        chk("s_ren", rom_r_en, 1);
        chk("s_addr", rom_addr, 4'd8);
        chk("s_busy0", busy, 1);
        req0 = 1'b0;
        tick;
        chk("s_ack0_off", ack0, 0);
        chk("s_ren_off", rom_r_en, 0);
        chk("s_busy1", busy, 1);
        chk("s_rv_early", rvalid0, 0);
        tick;
        chk("s_rv0", rvalid0, 1);
        chk("s_rv1", rvalid1, 0);
        chk("s_rdata", rdata, 16'hcafe);
        chk("s_busy2", busy, 0);
        tick;
        chk("s_rv0_off", rvalid0, 0);
        chk("s_rdata_hold", rdata, 16'hcafe);

        // contention from reset
        do_reset;
        req0 = 1'b1; addr0 = 4'd2;
        req1 = 1'b1; addr1 = 4'd11;
        tick;
        chk("c_ack0", ack0, 1);
        chk("c_ack1", ack1, 0);
        req0 = 1'b0;
        tick;
        tick;
        chk("c_rv0", rvalid0, 1);
        chk("c_rdata0", rdata, 16'he0b9);
        tick;
        chk("c_ack1b", ack1, 1);
        chk("c_addr1", rom_addr, 4'd11);
        req1 = 1'b0;
        tick;
        tick;
        chk("c_rv1", rvalid1, 1);
        chk("c_rv0_off", rvalid0, 0);
        chk("c_rdata1", rdata, 16'haeec);

        // fairness with both held
        do_reset;
        req0 = 1'b1; addr0 = 4'd4;
        req1 = 1'b1; addr1 = 4'd15;
        for (int k = 0; k < 4; k++) begin
            tick;
            tick;
            tick;
            chk("f_rv0", rvalid0, (k % 2 == 0) ? 1 : 0);
            chk("f_rv1", rvalid1, (k % 2 == 0) ? 0 : 1);
            chk("f_rdata", rdata, (k % 2 == 0) ? 16'h4839 : 16'h5555);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick;
        tick;
        chk("f_idle", busy, 0);

        // sweep of requester 1
        consec = 1'b0;
        for (int a = 0; a < 16; a++) begin
            req1  = 1'b1;
            addr1 = 4'(a);
            got   = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick;
                if (ack1) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("w_ack1", got, 1);
            req1 = 1'b0;
            got  = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick;
                if (rvalid1) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("w_rv1", got, 1);
            chk("w_rdata", rdata, mem[a]);
        end
        chk("w_ren_consec", consec, 0);

        // reset in WAIT
        req0 = 1'b1; addr0 = 4'd9;
        tick;
        chk("r_ack0", ack0, 1);
        req0 = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        chk("r_flags", flags(), 6'b0);
        chk("r_addr", rom_addr, 4'd0);
        chk("r_rdata", rdata, 16'h0);
        tick;
        tick;
        rst = 1'b0;
        chk("r_no_rv0", rvalid0, 0);
        req1 = 1'b1; addr1 = 4'd13;
        tick;
        chk("r_ack1", ack1, 1);
        req1 = 1'b0;
        tick;
        tick;
        chk("r_rv1", rvalid1, 1);
        chk("r_rdata1", rdata, 16'h1113);

        // idle
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("i_flags", flags(), 6'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rom_rr_arbiter.md
# rom_rr_arbiter

Round-robin read arbiter that shares one synchronous 16x16 ROM read port (clk, r_en, addr, data; data registered on the clock edge where r_en is high) between two requesters. Each requester presents an address with a level request; the arbiter grants one read at a time, drives the ROM port from registers, captures the ROM word and returns it with a one-cycle valid pulse to the owning requester. It sits between the ROM instance and its two client blocks.

## Interface
- ADDR_W, 4, ROM address width (16 words)
- DATA_W, 16, ROM word width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 read request, level; held with addr0 until ack0
- addr0  in  ADDR_W  requester 0 address
- req1  in  1  requester 1 read request, level; held with addr1 until ack1
- addr1  in  ADDR_W  requester 1 address
- ack0  out  1  one-cycle pulse: requester 0 request accepted
- ack1  out  1  one-cycle pulse: requester 1 request accepted
- rvalid0  out  1  one-cycle pulse: rdata holds requester 0 result
- rvalid1  out  1  one-cycle pulse: rdata holds requester 1 result
- rdata  out  DATA_W  returned ROM word, shared; held until next capture
- busy  out  1  high when state is not IDLE
- rom_r_en  out  1  to ROM r_en
- rom_addr  out  ADDR_W  to ROM addr
- rom_data  in  DATA_W  from ROM data

## Operation
- States: IDLE, ISSUE, WAIT. All outputs registered.
- IDLE: if no req, stay. If any req, select winner, register rom_addr <= winner address, rom_r_en <= 1, ack_winner <= 1, owner <= winner, last <= winner; go ISSUE.
- Arbitration: single requester always wins. Both requesting: grant the requester other than last. last resets to 1, so requester 0 wins the first contention.
- ISSUE (ROM samples r_en/addr on this edge): rom_r_en <= 0, ack <= 0; go WAIT. req inputs ignored.
- WAIT: rdata <= rom_data, rvalid_owner <= 1; go IDLE. req inputs ignored.
- A requester holding req high after its ack is a new request, arbitrated on the next IDLE cycle.
- rom_addr holds its last value when rom_r_en is low. rdata is never cleared except by reset.
- No pipelining: one read in flight; max throughput one read per 3 cycles.

## Timing
- Reset values: state IDLE, rom_r_en 0, rom_addr 0, ack0/ack1 0, rvalid0/rvalid1 0, rdata 0, busy 0, owner 0, last 1.
- Edge E0 (IDLE, req sampled): ack and rom_r_en high for exactly cycle E0..E1; busy high from E0 until E2.
- Edge E1: ROM captures word; rom_data valid after E1.
- Edge E2: rdata updated, rvalid high for cycle E2..E3; state IDLE, so a pending req is accepted at E3.
- Latency req-sampled to rvalid: 2 edges; back-to-back request period: 3 cycles.
- Simultaneous req0/req1 at E0: exactly one ack; the loser stays pending and is granted at E3.
- rst asserted mid-read (ISSUE or WAIT): outputs go to reset values immediately; in-flight read discarded, no rvalid issued; after rst deasserts, arbitration restarts with last = 1.
- req dropped before ack: no read, no ack.

## Test plan
- ROM preloaded mem[0..15] = 0103,5200,e0b9,0412,4839,0112,0377,0572,cafe,6225,1447,aeec,52dd,1113,4444,5555 (hex).
- Single read: req0=1, addr0=8 -> ack0 pulse 1 cycle, rom_r_en=1 with rom_addr=8, two edges later rvalid0 pulse with rdata=16'hcafe; rvalid1 stays 0.
- Contention: req0 addr0=2 and req1 addr1=11 raised together from reset -> requester 0 first (rdata=16'he0b9, rvalid0), then requester 1 (rdata=16'haeec, rvalid1) exactly 3 cycles later.
- Fairness: both held high continuously with addr0=4, addr1=15 -> rvalid alternates 0,1,0,1 every 3 cycles with rdata 4839,5555,4839,5555.
- Sweep: requester 1 alone, addr1 0..15 each held until ack1 -> 16 rvalid1 pulses, rdata matches preload in order; rom_r_en never high two consecutive cycles.
- Reset mid-read: req0 addr0=9, assert rst in WAIT -> all outputs 0 at once, no rvalid0; after release, req1 addr1=13 -> rdata=16'h1113 with rvalid1.
- Idle: no requests for 20 cycles -> rom_r_en, ack*, rvalid*, busy all 0.
